// File: rtl/uart_rx_framer_if.sv
// Output bundle from the UART RX framer to the serial-to-parallel shifter.
// The parity_err signal exists only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps

interface uart_rx_framer_if;
  logic ser_bit;
  logic shift_en;
  logic char_receive;
  logic framing_err;
  logic busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  // Framer drives the strobes.
  modport master (
    output ser_bit,
    output shift_en,
    output char_receive,
    output framing_err,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output busy
  );

  // Shifter consumes the strobes.
  modport slave (
    input ser_bit,
    input shift_en,
    input char_receive,
    input framing_err,
`ifdef UART_RX_PARITY_EN
    input parity_err,
`endif
    input busy
  );
endinterface

// File: rtl/uart_rx_framer.sv
// UART receive framer: synchronises rxd, finds start bits on an oversampled tick,
// emits one shift_en per data bit (LSB first) and a char_receive / framing_err at the stop bit.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit and the parity_err strobe.
`timescale 1ns/1ps

module uart_rx_framer #(
  parameter int unsigned CLK_DIV    = 326,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  uart_rx_framer_if.master bus
);

  localparam int unsigned DivW  = $clog2(CLK_DIV);
  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS);

  localparam logic [DivW-1:0]  DivMax  = DivW'(CLK_DIV - 1);
  localparam logic [TickW-1:0] TickMax = TickW'(OVERSAMPLE - 1);
  localparam logic [TickW-1:0] HalfMax = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [BitW-1:0]  BitMax  = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
`ifdef UART_RX_PARITY_EN
    , StParity
`endif
  } state_e;

  state_e           state_q;
  logic             sync_q;
  logic             rx_s;
  logic [DivW-1:0]  div_q;
  logic [TickW-1:0] tick_cnt_q;
  logic [BitW-1:0]  bit_cnt_q;
  logic             tick;
  logic             ser_bit_q;
  logic             shift_en_q;
  logic             char_receive_q;
  logic             framing_err_q;
`ifdef UART_RX_PARITY_EN
  logic             parity_acc_q;
  logic             parity_err_q;
`endif

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= rxd;
      rx_s   <= sync_q;
    end
  end

  assign tick = (div_q == DivMax);

  // Tick divider, held at zero in IDLE so sampling phase is aligned to the start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else if (state_q == StIdle || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  // Frame FSM with registered one-cycle strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      tick_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      ser_bit_q      <= 1'b0;
      shift_en_q     <= 1'b0;
      char_receive_q <= 1'b0;
      framing_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_acc_q   <= 1'b0;
      parity_err_q   <= 1'b0;
`endif
    end else begin
      shift_en_q     <= 1'b0;
      char_receive_q <= 1'b0;
      framing_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q   <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            tick_cnt_q <= '0;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            if (tick_cnt_q == HalfMax) begin
              // Mid start bit: a high line here means the low pulse was a glitch.
              if (rx_s) begin
                state_q <= StIdle;
              end else begin
                tick_cnt_q   <= '0;
                bit_cnt_q    <= '0;
`ifdef UART_RX_PARITY_EN
                parity_acc_q <= 1'b0;
`endif
                state_q      <= StData;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
          end
        end
        StData: begin
          if (tick) begin
            if (tick_cnt_q == TickMax) begin
              tick_cnt_q   <= '0;
              ser_bit_q    <= rx_s;
              shift_en_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_acc_q <= parity_acc_q ^ rx_s;
`endif
              if (bit_cnt_q == BitMax) begin
                bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                state_q   <= StParity;
`else
                state_q   <= StStop;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + BitW'(1);
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (tick) begin
            if (tick_cnt_q == TickMax) begin
              tick_cnt_q   <= '0;
              parity_err_q <= parity_acc_q ^ rx_s;
              state_q      <= StStop;
            end else begin
              tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
          end
        end
`endif
        StStop: begin
          if (tick) begin
            if (tick_cnt_q == TickMax) begin
              tick_cnt_q <= '0;
              if (rx_s) begin
                char_receive_q <= 1'b1;
                state_q        <= StIdle;
              end else begin
                framing_err_q <= 1'b1;
                state_q       <= StBreak;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
          end
        end
        StBreak: begin
          // Line held low past the stop bit; wait for it to return high.
          if (rx_s) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ser_bit      = ser_bit_q;
  assign bus.shift_en     = shift_en_q;
  assign bus.char_receive = char_receive_q;
  assign bus.framing_err  = framing_err_q;
  assign bus.busy         = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer (CLK_DIV=4, OVERSAMPLE=16 -> 64 clk per bit).
// Stimulus pushes expected strobe events; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_uart_rx_framer;

  localparam int BitClk = 64;
  localparam int KShift = 0;
  localparam int KPerr  = 1;
  localparam int KChar  = 2;
  localparam int KFerr  = 3;

  typedef struct {
    int   kind;
    logic bit_v;
    int   gap;
  } ev_t;

  logic clk;
  logic reset;
  logic rxd;

  uart_rx_framer_if bus_if ();

  uart_rx_framer #(
    .CLK_DIV    (4),
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd),
    .bus   (bus_if)
  );

  int          n_pass = 0;
  int          n_total = 0;
  int unsigned cyc = 0;
  int unsigned last_ev = 0;
  int          fired;
  ev_t         exp_q[$];
  int unsigned char_times[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic observe(input int kind, input logic b);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == KShift && e.kind == KShift) check("ser_bit", b, e.bit_v);
      if (e.gap >= 0) check("event_gap", cyc - last_ev, e.gap);
    end
    last_ev = cyc;
  endtask

  // Monitor: every strobe is matched against the scoreboard queue.
  always @(negedge clk) begin
    fired = int'(bus_if.shift_en) + int'(bus_if.char_receive) + int'(bus_if.framing_err);
    if (fired > 0) check("strobe_exclusive", fired, 1);
    if (bus_if.shift_en) observe(KShift, bus_if.ser_bit);
`ifdef UART_RX_PARITY_EN
    if (bus_if.parity_err) observe(KPerr, 1'b0);
`endif
    if (bus_if.char_receive) begin
      char_times.push_back(cyc);
      observe(KChar, 1'b0);
    end
    if (bus_if.framing_err) observe(KFerr, 1'b0);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic push_ev(input int kind, input logic b, input int gap);
    ev_t e;
    e.kind  = kind;
    e.bit_v = b;
    e.gap   = gap;
    exp_q.push_back(e);
  endtask

  // Drives one frame; rxd is left at the stop level afterwards.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_len,
                            input logic use_par, input logic par_bit, input logic exp_perr);
    for (int i = 0; i < 8; i++) push_ev(KShift, d[i], (i == 0) ? -1 : BitClk);
    if (use_par && exp_perr) push_ev(KPerr, 1'b0, BitClk);
    push_ev(stop_bit ? KChar : KFerr, 1'b0,
            (use_par && !exp_perr) ? 2 * BitClk : BitClk);
    rxd = 1'b0;
    wait_clk(BitClk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_clk(BitClk);
    end
    if (use_par) begin
      rxd = par_bit;
      wait_clk(BitClk);
    end
    rxd = stop_bit;
    wait_clk(stop_len);
  endtask

  initial begin
    logic [7:0] part;
    rxd   = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_ser_bit", bus_if.ser_bit, 0);
    check("rst_shift_en", bus_if.shift_en, 0);
    check("rst_char_receive", bus_if.char_receive, 0);
    check("rst_framing_err", bus_if.framing_err, 0);
    check("rst_busy", bus_if.busy, 0);
    wait_clk(3);
    reset = 1'b1;
    wait_clk(10);

    // Frame 0xA5 with a good stop bit.
    send_frame(8'hA5, 1'b1, BitClk, 1'b0, 1'b0, 1'b0);
    wait_clk(20);
    wait_drain(200);
    check("a5_busy_idle", bus_if.busy, 0);

    // 20 clk low glitch while idle must be rejected.
    rxd = 1'b0;
    wait_clk(20);
    rxd = 1'b1;
    wait_clk(100);
    check("glitch_busy", bus_if.busy, 0);
    check("glitch_no_events", exp_q.size(), 0);

    // Frame 0x3C with stop bit low, line held low 200 clk.
    send_frame(8'h3C, 1'b0, 200, 1'b0, 1'b0, 1'b0);
    check("break_busy", bus_if.busy, 1);
    wait_drain(10);
    rxd = 1'b1;
    wait_clk(6);
    check("break_release_busy", bus_if.busy, 0);
    wait_clk(50);

    // Back-to-back 0x00 then 0xFF, no idle gap.
    char_times.delete();
    send_frame(8'h00, 1'b1, BitClk, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, BitClk, 1'b0, 1'b0, 1'b0);
    wait_clk(20);
    wait_drain(200);
    check("b2b_char_count", char_times.size(), 2);
    if (char_times.size() == 2) check("b2b_char_spacing", char_times[1] - char_times[0], 640);

    // Reset during data bit 4 of a partial frame.
    part = 8'h6B;
    for (int i = 0; i < 4; i++) push_ev(KShift, part[i], (i == 0) ? -1 : BitClk);
    rxd = 1'b0;
    wait_clk(BitClk);
    for (int i = 0; i < 4; i++) begin
      rxd = part[i];
      wait_clk(BitClk);
    end
    rxd = part[4];
    wait_clk(20);
    check("pre_reset_busy", bus_if.busy, 1);
    check("pre_reset_drained", exp_q.size(), 0);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", bus_if.busy, 0);
    check("mid_rst_ser_bit", bus_if.ser_bit, 0);
    check("mid_rst_shift_en", bus_if.shift_en, 0);
    check("mid_rst_char_receive", bus_if.char_receive, 0);
    check("mid_rst_framing_err", bus_if.framing_err, 0);
    rxd = 1'b1;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(20);
    send_frame(8'h5A, 1'b1, BitClk, 1'b0, 1'b0, 1'b0);
    rxd = 1'b1;
    wait_clk(20);
    wait_drain(200);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: parity bit 0 is wrong, 1 is right.
    send_frame(8'h07, 1'b1, BitClk, 1'b1, 1'b0, 1'b1);
    wait_clk(20);
    wait_drain(200);
    send_frame(8'h07, 1'b1, BitClk, 1'b1, 1'b1, 1'b0);
    wait_clk(20);
    wait_drain(200);
`endif

    wait_clk(100);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_busy", bus_if.busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
